// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle controller: state encodings,
// opcodes, datapath select codes and the DECODE dispatch function.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_R    = 4'd3,
    ST_EXEC_I    = 4'd4,
    ST_WB_R      = 4'd5,
    ST_WB_I      = 4'd6,
    ST_MEM_ADDR  = 4'd7,
    ST_MEM_RD    = 4'd8,
    ST_MEM_WR    = 4'd9,
    ST_WB_MEM    = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12,
    ST_HALT      = 4'd13,
    ST_ILLEGAL   = 4'd14,
    ST_STEP_WAIT = 4'd15
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_J     = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic state_e decode_target(input logic [3:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE:      nxt = ST_EXEC_R;
      OP_ADDI:       nxt = ST_EXEC_I;
      OP_LW, OP_SW:  nxt = ST_MEM_ADDR;
      OP_BEQ, OP_BNE: nxt = ST_BRANCH;
      OP_J:          nxt = ST_JUMP;
      OP_HALT:       nxt = ST_HALT;
      default:       nxt = ST_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational decode of the registered state into datapath strobes and
// selects; only FETCH and BRANCH look at the same-cycle qualifiers.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] op_i,
  input  logic       is_zero_i,
  input  logic       mem_ready_i,
  output logic       ir_wrt_o,
  output logic       reg_wrt_o,
  output logic       pc_wrt_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       i_or_d_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_sel_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] pc_src_o,
  output logic       halted_o,
  output logic       illegal_o
);

  always_comb begin
    ir_wrt_o     = 1'b0;
    reg_wrt_o    = 1'b0;
    pc_wrt_o     = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    i_or_d_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    alu_op_sel_o = ALUOP_ADD;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    pc_src_o     = PCSRC_ALU;
    halted_o     = 1'b0;
    illegal_o    = 1'b0;
    case (state_i)
      ST_FETCH: begin
        mem_rd_o    = 1'b1;
        alu_src_b_o = SRCB_TWO;
        ir_wrt_o    = mem_ready_i;
        pc_wrt_o    = mem_ready_i;
      end
      ST_DECODE: alu_src_b_o = SRCB_IMM_SH;
      ST_EXEC_R: begin
        alu_src_a_o  = 1'b1;
        alu_op_sel_o = ALUOP_FUNC;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ST_WB_R: begin
        reg_wrt_o = 1'b1;
        reg_dst_o = 1'b1;
      end
      ST_WB_I: reg_wrt_o = 1'b1;
      ST_MEM_RD: begin
        mem_rd_o = 1'b1;
        i_or_d_o = 1'b1;
      end
      ST_MEM_WR: begin
        mem_wr_o = 1'b1;
        i_or_d_o = 1'b1;
      end
      ST_WB_MEM: begin
        reg_wrt_o    = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_sel_o = ALUOP_SUB;
        pc_src_o     = PCSRC_ALUOUT;
        // BEQ/BNE differ only in the sense of the zero flag.
        if (op_i == OP_BEQ) begin
          pc_wrt_o = is_zero_i;
        end else if (op_i == OP_BNE) begin
          pc_wrt_o = ~is_zero_i;
        end else begin
          pc_wrt_o = 1'b0;
        end
      end
      ST_JUMP: begin
        pc_src_o = PCSRC_JUMP;
        pc_wrt_o = 1'b1;
      end
      ST_HALT:    halted_o  = 1'b1;
      ST_ILLEGAL: illegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM and retired-instruction counter for the 16-bit datapath.
// Optional macro MULTICYCLE_CTRL_SINGLE_STEP_EN adds a step input and STEP_WAIT state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [OP_W-1:0]  op_code,
  input  logic             is_zero,
  input  logic             mem_ready,
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             ir_wrt,
  output logic             reg_wrt,
  output logic             pc_wrt,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             i_or_d,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op_sel,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  localparam state_e RET_NEXT = ST_STEP_WAIT;
`else
  localparam state_e RET_NEXT = ST_FETCH;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire_s;
  logic [3:0]        op4_s;

  assign op4_s = 4'(op_code);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d  = decode_target(op4_s);
        // HALT retires once on the edge that enters it, never again.
        retire_s = (op4_s == OP_HALT);
      end
      ST_EXEC_R: state_d = ST_WB_R;
      ST_EXEC_I: state_d = ST_WB_I;
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
        retire_s = 1'b1;
        state_d  = RET_NEXT;
      end
      ST_MEM_ADDR: begin
        if (op4_s == OP_LW) begin
          state_d = ST_MEM_RD;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        if (mem_ready) begin
          state_d = ST_WB_MEM;
        end else begin
          state_d = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        if (mem_ready) begin
          retire_s = 1'b1;
          state_d  = RET_NEXT;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_HALT:    state_d = ST_HALT;
      ST_ILLEGAL: state_d = ST_ILLEGAL;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
      ST_STEP_WAIT: begin
        if (step) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
`else
      ST_STEP_WAIT: state_d = ST_ILLEGAL;
`endif
      default: state_d = ST_ILLEGAL;
    endcase
  end

  // Counter wraps silently at 2^CNT_W.
  always_comb begin
    if (retire_s) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  ctrl_out_decode u_decode (
    .state_i      (state_q),
    .op_i         (op4_s),
    .is_zero_i    (is_zero),
    .mem_ready_i  (mem_ready),
    .ir_wrt_o     (ir_wrt),
    .reg_wrt_o    (reg_wrt),
    .pc_wrt_o     (pc_wrt),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .i_or_d_o     (i_or_d),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_sel_o (alu_op_sel),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .pc_src_o     (pc_src),
    .halted_o     (halted),
    .illegal_o    (illegal)
  );

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected states queued as
// stimulus is scheduled, outputs compared against an independent control table.
module tb_multicycle_ctrl;

  localparam int TB_CNT_W = 8;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  localparam logic [3:0] AFTER_RET = 4'd15;
  localparam int R_CYC = 5;
`else
  localparam logic [3:0] AFTER_RET = 4'd1;
  localparam int R_CYC = 4;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic [3:0] op_code = 4'h0;
  logic is_zero = 1'b0;
  logic mem_ready = 1'b0;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  logic ir_wrt, reg_wrt, pc_wrt, mem_rd, mem_wr, i_or_d, alu_src_a;
  logic [1:0] alu_src_b, alu_op_sel, pc_src;
  logic reg_dst, mem_to_reg, halted, illegal;
  logic [3:0] state;
  logic [TB_CNT_W-1:0] retired;
  logic [17:0] ctrl_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       z;
    logic       stp;
  } cyc_t;
  cyc_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(4), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .op_code(op_code),
    .is_zero(is_zero), .mem_ready(mem_ready),
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .ir_wrt(ir_wrt), .reg_wrt(reg_wrt), .pc_wrt(pc_wrt), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .halted(halted),
    .illegal(illegal), .state(state), .retired(retired)
  );

  assign ctrl_s = {ir_wrt, reg_wrt, pc_wrt, mem_rd, mem_wr, i_or_d, alu_src_a,
                   alu_src_b, alu_op_sel, reg_dst, mem_to_reg, pc_src, halted, illegal};

  // Expected control word per state, written from the state/output table.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [3:0] op,
                                           input logic z, input logic mr);
    logic ir, rw, pw, mrd, mwr, iod, a, rd, m2r, h, il;
    logic [1:0] b, aop, ps;
    {ir, rw, pw, mrd, mwr, iod, a, rd, m2r, h, il} = 11'b0;
    b = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin mrd = 1'b1; b = 2'b01; ir = mr; pw = mr; end
      4'd2:  b = 2'b11;
      4'd3:  begin a = 1'b1; aop = 2'b10; end
      4'd4:  begin a = 1'b1; b = 2'b10; end
      4'd5:  begin rw = 1'b1; rd = 1'b1; end
      4'd6:  rw = 1'b1;
      4'd7:  begin a = 1'b1; b = 2'b10; end
      4'd8:  begin mrd = 1'b1; iod = 1'b1; end
      4'd9:  begin mwr = 1'b1; iod = 1'b1; end
      4'd10: begin rw = 1'b1; m2r = 1'b1; end
      4'd11: begin a = 1'b1; aop = 2'b01; ps = 2'b01; pw = (op == 4'h4) ? z : ~z; end
      4'd12: begin ps = 2'b10; pw = 1'b1; end
      4'd13: h = 1'b1;
      4'd14: il = 1'b1;
      default: ;
    endcase
    return {ir, rw, pw, mrd, mwr, iod, a, b, aop, rd, m2r, ps, h, il};
  endfunction

  task automatic push_cyc(input logic [3:0] st, input logic mr, input logic z, input logic stp);
    exp_q.push_back({st, mr, z, stp});
  endtask

  task automatic push_after_retire();
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    push_cyc(4'd15, 1'b1, 1'b0, 1'b1);
`endif
  endtask

  // Pops one scheduled cycle, drives its inputs and waits for mid-cycle sampling.
  task automatic drive_next(output cyc_t e);
    e = exp_q.pop_front();
    mem_ready = e.mr;
    is_zero   = e.z;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    step = e.stp;
`endif
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc_t e;
    reset = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (ctrl_s !== 18'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_s); end
    checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    push_cyc(4'd0, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd0, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      drive_next(e);
      checks++; if (state !== e.st) begin errors++; $display("FAIL idle_state: got %0d expected %0d", state, e.st); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    cyc_t e;
    run = 1'b1; op_code = 4'h0;
    push_cyc(4'd0, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd1, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd2, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd3, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd5, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      drive_next(e);
      checks++; if (state !== e.st) begin errors++; $display("FAIL rtype_state: got %0d expected %0d", state, e.st); end
      checks++; if (ctrl_s !== exp_ctrl(e.st, op_code, e.z, e.mr)) begin errors++; $display("FAIL rtype_ctrl st%0d: got %h expected %h", e.st, ctrl_s, exp_ctrl(e.st, op_code, e.z, e.mr)); end
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd1) begin errors++; $display("FAIL rtype_retired: got %0d expected 1", retired); end
    checks++; if (state !== AFTER_RET) begin errors++; $display("FAIL rtype_next: got %0d expected %0d", state, AFTER_RET); end
  endtask

  task automatic test_mem();
    cyc_t e;
    push_after_retire();
    op_code = 4'h2;
    push_cyc(4'd1, 1'b1, 1'b0, 1'b1); push_cyc(4'd2, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd7, 1'b1, 1'b0, 1'b1); push_cyc(4'd8, 1'b0, 1'b0, 1'b1);
    push_cyc(4'd8, 1'b0, 1'b0, 1'b1); push_cyc(4'd8, 1'b0, 1'b0, 1'b1);
    push_cyc(4'd8, 1'b1, 1'b0, 1'b1); push_cyc(4'd10, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      drive_next(e);
      checks++; if (state !== e.st) begin errors++; $display("FAIL lw_state: got %0d expected %0d", state, e.st); end
      checks++; if (ctrl_s !== exp_ctrl(e.st, op_code, e.z, e.mr)) begin errors++; $display("FAIL lw_ctrl st%0d: got %h expected %h", e.st, ctrl_s, exp_ctrl(e.st, op_code, e.z, e.mr)); end
      checks++; if ((32'(ir_wrt) + 32'(reg_wrt) + 32'(mem_wr)) > 1) begin errors++; $display("FAIL lw_excl: got %b%b%b expected at most one", ir_wrt, reg_wrt, mem_wr); end
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd2) begin errors++; $display("FAIL lw_retired: got %0d expected 2", retired); end
    push_after_retire();
    op_code = 4'h3;
    push_cyc(4'd1, 1'b0, 1'b0, 1'b1); push_cyc(4'd1, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd2, 1'b1, 1'b0, 1'b1); push_cyc(4'd7, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd9, 1'b0, 1'b0, 1'b1); push_cyc(4'd9, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      drive_next(e);
      checks++; if (state !== e.st) begin errors++; $display("FAIL sw_state: got %0d expected %0d", state, e.st); end
      checks++; if (ctrl_s !== exp_ctrl(e.st, op_code, e.z, e.mr)) begin errors++; $display("FAIL sw_ctrl st%0d: got %h expected %h", e.st, ctrl_s, exp_ctrl(e.st, op_code, e.z, e.mr)); end
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd3) begin errors++; $display("FAIL sw_retired: got %0d expected 3", retired); end
  endtask

  task automatic test_branch_jump();
    cyc_t e;
    logic [TB_CNT_W-1:0] exp_ret;
    exp_ret = 8'd3;
    for (int k = 0; k < 5; k++) begin
      op_code = (k < 2) ? 4'h4 : ((k < 4) ? 4'h5 : 4'h6);
      push_after_retire();
      push_cyc(4'd1, 1'b1, 1'b0, 1'b1);
      push_cyc(4'd2, 1'b1, 1'b0, 1'b1);
      push_cyc((k < 4) ? 4'd11 : 4'd12, 1'b1, (k % 2) == 0, 1'b1);
      exp_ret = exp_ret + 8'd1;
      while (exp_q.size() > 0) begin
        drive_next(e);
        checks++; if (state !== e.st) begin errors++; $display("FAIL br%0d_state: got %0d expected %0d", k, state, e.st); end
        checks++; if (ctrl_s !== exp_ctrl(e.st, op_code, e.z, e.mr)) begin errors++; $display("FAIL br%0d_ctrl st%0d: got %h expected %h", k, e.st, ctrl_s, exp_ctrl(e.st, op_code, e.z, e.mr)); end
        @(posedge clk); #1;
      end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL br%0d_retired: got %0d expected %0d", k, retired, exp_ret); end
    end
  endtask

  task automatic test_illegal_and_abort();
    cyc_t e;
    push_after_retire();
    op_code = 4'h9;
    push_cyc(4'd1, 1'b1, 1'b0, 1'b1); push_cyc(4'd2, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd14, 1'b1, 1'b0, 1'b1); push_cyc(4'd14, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd14, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      drive_next(e);
      checks++; if (state !== e.st) begin errors++; $display("FAIL ill_state: got %0d expected %0d", state, e.st); end
      checks++; if (ctrl_s !== exp_ctrl(e.st, op_code, e.z, e.mr)) begin errors++; $display("FAIL ill_ctrl st%0d: got %h expected %h", e.st, ctrl_s, exp_ctrl(e.st, op_code, e.z, e.mr)); end
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd8) begin errors++; $display("FAIL ill_retired: got %0d expected 8", retired); end
    apply_reset();
    run = 1'b1; op_code = 4'h0; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL abort_in_fetch: got mem_rd %b expected 1", mem_rd); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", state); end
    checks++; if (ctrl_s !== 18'd0) begin errors++; $display("FAIL abort_ctrl: got %h expected 0", ctrl_s); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_wrap_halt();
    cyc_t e;
    apply_reset();
    run = 1'b1; op_code = 4'h0; mem_ready = 1'b1;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 255 * R_CYC; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd255) begin errors++; $display("FAIL wrap_max: got %0d expected 255", retired); end
    for (int i = 0; i < R_CYC; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", retired); end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL wrap_state: got %0d expected 1", state); end
    op_code = 4'hF; run = 1'b0;
    push_cyc(4'd1, 1'b1, 1'b0, 1'b1); push_cyc(4'd2, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd13, 1'b1, 1'b0, 1'b1); push_cyc(4'd13, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd13, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      drive_next(e);
      checks++; if (state !== e.st) begin errors++; $display("FAIL halt_state: got %0d expected %0d", state, e.st); end
      checks++; if (ctrl_s !== exp_ctrl(e.st, op_code, e.z, e.mr)) begin errors++; $display("FAIL halt_ctrl st%0d: got %h expected %h", e.st, ctrl_s, exp_ctrl(e.st, op_code, e.z, e.mr)); end
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd1) begin errors++; $display("FAIL halt_retired: got %0d expected 1", retired); end
  endtask

`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  task automatic test_step();
    cyc_t e;
    apply_reset();
    run = 1'b1; op_code = 4'h0;
    push_cyc(4'd0, 1'b1, 1'b0, 1'b0); push_cyc(4'd1, 1'b1, 1'b0, 1'b0);
    push_cyc(4'd2, 1'b1, 1'b0, 1'b0); push_cyc(4'd3, 1'b1, 1'b0, 1'b0);
    push_cyc(4'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_cyc(4'd15, 1'b1, 1'b0, 1'b0);
    push_cyc(4'd15, 1'b1, 1'b0, 1'b1);
    push_cyc(4'd1, 1'b1, 1'b0, 1'b0); push_cyc(4'd2, 1'b1, 1'b0, 1'b0);
    push_cyc(4'd3, 1'b1, 1'b0, 1'b0); push_cyc(4'd5, 1'b1, 1'b0, 1'b0);
    push_cyc(4'd15, 1'b1, 1'b0, 1'b0); push_cyc(4'd15, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      drive_next(e);
      checks++; if (state !== e.st) begin errors++; $display("FAIL step_state: got %0d expected %0d", state, e.st); end
      checks++; if (ctrl_s !== exp_ctrl(e.st, op_code, e.z, e.mr)) begin errors++; $display("FAIL step_ctrl st%0d: got %h expected %h", e.st, ctrl_s, exp_ctrl(e.st, op_code, e.z, e.mr)); end
      @(posedge clk); #1;
    end
    checks++; if (retired !== 8'd2) begin errors++; $display("FAIL step_retired: got %0d expected 2", retired); end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch_jump();
    test_illegal_and_abort();
    test_wrap_halt();
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    test_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the 16-bit datapath: 8x16 register file, instruction register, ALU/ALU-control pair, PC and memory port.
- Each cycle it issues the write enables, mux selects and memory strobes.
- It consumes the IR opcode and the ALU zero flag, and counts retired instructions.

Parameters:
- OP_W, 4, opcode width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; leaves IDLE when high
- op_code  in  OP_W  opcode from IR output
- is_zero  in  1  ALU zero flag (combinational, same cycle)
- mem_ready  in  1  memory completes the current access this cycle
- ir_wrt  out  1  IR load
- reg_wrt  out  1  register file write
- pc_wrt  out  1  PC load
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUout
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = r1out
- alu_src_b  out  2  ALU B select: 00 = r2out, 01 = const 2, 10 = sign-ext imm, 11 = imm<<1
- alu_op_sel  out  2  to ALU control: 00 = add, 01 = sub, 10 = use funcCode
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALUout, 1 = MDR
- pc_src  out  2  PC source select: 00 = ALU result, 01 = ALUout (branch target), 10 = jump target
- halted  out  1  in HALT state
- illegal  out  1  in ILLEGAL state
- state  out  4  current state encoding (debug)
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Moore FSM: all outputs decode from the registered state only, except the mem_ready and is_zero qualifiers below.
- Reset:
  - state = IDLE, retired = 0.
  - All strobes/enables = 0; all selects = 0.
  - Asserting reset mid-instruction aborts it immediately; no partial writes follow.
- Opcodes:
  - 0x0 R-type, 0x1 ADDI, 0x2 LW, 0x3 SW, 0x4 BEQ, 0x5 BNE, 0x6 J, 0xF HALT.
  - All other opcodes are illegal.
- IDLE (0): go to FETCH when run = 1.
- FETCH (1):
  - Asserts mem_rd, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op_sel = 00, pc_src = 00.
  - ir_wrt and pc_wrt are asserted only in a cycle where mem_ready = 1; that cycle moves to DECODE.
  - With mem_ready = 0, FETCH holds and no state changes.
- DECODE (2):
  - Sets alu_src_a = 0, alu_src_b = 11, alu_op_sel = 00 (branch target to ALUout).
  - Next state by op_code: 0x0 -> EXEC_R; 0x1 -> EXEC_I; 0x2/0x3 -> MEM_ADDR; 0x4/0x5 -> BRANCH; 0x6 -> JUMP; 0xF -> HALT; otherwise -> ILLEGAL.
- EXEC_R (3): alu_src_a = 1, alu_src_b = 00, alu_op_sel = 10; then WB_R.
- EXEC_I (4): alu_src_a = 1, alu_src_b = 10, alu_op_sel = 00; then WB_I.
- WB_R (5) / WB_I (6):
  - reg_wrt = 1, mem_to_reg = 0.
  - reg_dst = 1 in WB_R, 0 in WB_I.
  - Retire, then FETCH.
- MEM_ADDR (7): alu_src_a = 1, alu_src_b = 10, alu_op_sel = 00; LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD (8): mem_rd = 1, i_or_d = 1; hold until mem_ready, then WB_MEM.
- MEM_WR (9): mem_wr = 1, i_or_d = 1; hold until mem_ready, then retire and go to FETCH.
- WB_MEM (10): reg_wrt = 1, mem_to_reg = 1, reg_dst = 0; retire, then FETCH.
- BRANCH (11):
  - alu_src_a = 1, alu_src_b = 00, alu_op_sel = 01, pc_src = 01.
  - pc_wrt = is_zero for BEQ, !is_zero for BNE (opcode held in IR).
  - Retire, then FETCH.
- JUMP (12): pc_src = 10, pc_wrt = 1; retire, then FETCH.
- HALT (13): halted = 1; retire once on entry; stays until reset.
- ILLEGAL (14): illegal = 1; no retire; stays until reset.
- Latency with zero-wait memory (mem_ready tied 1):
  - R/I-type 4 cycles; LW 5; SW 4; BEQ/BNE/J 3.
  - Each wait cycle adds 1 in FETCH, MEM_RD or MEM_WR.
- retired:
  - Increments by 1 on the clock edge leaving a retiring state.
  - Wraps from 2^CNT_W - 1 to 0, with no flag.
- run deasserted after leaving IDLE has no effect; the FSM never re-enters IDLE without reset.
- Unused encoding 15 -> ILLEGAL on the next edge.
- Any two of {reg_wrt, mem_wr, ir_wrt} are never high in the same cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_SINGLE_STEP_EN
- Defined:
  - Adds input step (1 bit).
  - After each retire the FSM enters STEP_WAIT (15), holding all strobes at 0, and proceeds to FETCH only on a cycle with step = 1.
  - A step held high steps every instruction.
- Undefined:
  - No step port; retiring states go directly to FETCH.
  - Encoding 15 is illegal.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (4-bit encodings above)
  - opcode constants
  - alu_src_b, alu_op_sel and pc_src select constants
- One sub-module, ctrl_out_decode: purely combinational state(+is_zero, mem_ready, opcode) -> control outputs. The FSM and counter stay in the top.

Test Plan:
- Reset then run = 1, mem_ready = 1, op_code = 0x0 -> states 0,1,2,3,5,1; reg_wrt = 1 with reg_dst = 1 only in WB_R; retired = 1.
- LW (0x2) with mem_ready low for 3 cycles in MEM_RD -> mem_rd held 4 cycles, i_or_d = 1; WB_MEM reg_wrt = 1, mem_to_reg = 1; total 8 cycles.
- BEQ with is_zero = 1 -> pc_wrt = 1, pc_src = 01 in BRANCH. Repeat with is_zero = 0 -> pc_wrt = 0. BNE inverted.
- op_code = 0x9 -> ILLEGAL, illegal = 1, retired unchanged; assert reset mid-FETCH of a later run -> all outputs 0 asynchronously.
- Preload-equivalent: run 65536 R-type instructions -> retired wraps to 0. HALT (0xF) -> halted = 1, retired increments exactly once.
- With MULTICYCLE_CTRL_SINGLE_STEP_EN: step = 0 after first retire -> state = 15 stays, no strobes; one-cycle step pulse -> exactly one more instruction executes.
